// File: rtl/seqdet_pkg.sv
// Shared types and reset defaults for the programmable sequence detector.
// Holds the FSM state enum, the default pattern, length and overlap, and the length-width helper.
package seqdet_pkg;

  typedef enum logic {
    RUN = 1'b0,
    HIT = 1'b1
  } state_e;

  localparam int PKG_DEF_PATTERN = 'b1010;
  localparam int PKG_DEF_LEN     = 4;
  localparam bit PKG_DEF_OVERLAP = 1'b0;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seqdet_if.sv
// Bundle of the detector's data, configuration and status signals.
// master: drives data/config and reads status; slave: the detector side.
interface seqdet_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  import seqdet_pkg::*;

  localparam int LW = len_w(MAX_LEN);

  logic               x;
  logic               in_valid;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output x, in_valid, cfg_we,
    output cfg_pattern, cfg_len,
    output cfg_overlap, cnt_clr,
    input  z, match_cnt, cfg_err
  );

  modport slave (
    input  x, in_valid, cfg_we,
    input  cfg_pattern, cfg_len,
    input  cfg_overlap, cnt_clr,
    output z, match_cnt, cfg_err
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Ports: clk, rst_n, clr, inc in; cnt out (W bits, holds at all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr: cnt_d = '0;
      !clr && inc && (cnt_q != '1):
        cnt_d = cnt_q + W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seqdet_prog.sv
// Programmable serial pattern detector with Moore match flag and match counter.
// Ports: clk, rst_n, x/in_valid data, cfg_* write port, cnt_clr; z, match_cnt, cfg_err out.
module seqdet_prog
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN     = 8,
  parameter int CNT_W       = 8,
  parameter int DEF_PATTERN = PKG_DEF_PATTERN,
  parameter int DEF_LEN     = PKG_DEF_LEN,
  parameter bit DEF_OVERLAP = PKG_DEF_OVERLAP,
  localparam int LW         = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LW-1:0]      LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0]      LEN_MIN = LW'(2);
  localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_PATTERN);
  localparam logic [LW-1:0]      RST_LEN = LW'(DEF_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               err_q, err_d;
  state_e             state_q, state_d;

  logic               cfg_ok;
  logic               accept;
  logic               match;
  logic [MAX_LEN-1:0] hist_sh;
  logic [MAX_LEN-1:0] mask;
  logic [LW:0]        fill_p1;

  assign cfg_ok  = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
  assign accept  = in_valid && !cfg_we;
  assign hist_sh = (hist_q << 1) | MAX_LEN'(x);
  assign fill_p1 = {1'b0, fill_q} + (LW+1)'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // fill counts the current bit too, hence fill+1
  assign match = accept
              && (fill_p1 >= {1'b0, len_q})
              && (((hist_sh ^ pat_q) & mask) == '0);

  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    err_d   = err_q;
    state_d = match ? HIT : RUN;
    unique case (1'b1)
      cfg_we && cfg_ok: begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end
      cfg_we && !cfg_ok: err_d = 1'b1;
      accept: begin
        hist_d = hist_sh;
        if (match && !ovl_q)
          fill_d = '0;
        else if (fill_q != LEN_MAX)
          fill_d = fill_p1[LW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= RST_PAT;
      len_q   <= RST_LEN;
      ovl_q   <= DEF_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
      state_q <= RUN;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (match),
    .cnt   (match_cnt)
  );

  assign z       = (state_q == HIT);
  assign cfg_err = err_q;

endmodule
